// File: rtl/ps2_scancode_tx.sv
// PS/2 set-2 device-side transmitter: key events -> scancode bytes -> 11-bit open-drain frames.
// Define PS2_TX_FIFO_EN to place a 4-entry event FIFO in front of the frame FSM.
module ps2_scancode_tx #(
   parameter int CLK_HALF = 2148,
   parameter int GAP_CYC  = 4296
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       key_valid_i,
   output logic       key_ready_o,
   input  logic [7:0] key_code_i,
   input  logic       key_ext_i,
   input  logic       key_pressed_i,
   input  logic       ps2_clk_i,
   output logic       ps2_clk_o,
   output logic       ps2_data_o,
   output logic       busy_o
);

   localparam int CNT_MAX = (CLK_HALF > GAP_CYC) ? CLK_HALF : GAP_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

   // Position within the byte sequence of one event.
   localparam logic [1:0] STG_E0   = 2'd0;
   localparam logic [1:0] STG_F0   = 2'd1;
   localparam logic [1:0] STG_CODE = 2'd2;

   typedef enum logic [2:0] {IDLE, LINECHK, BIT_HI, BIT_LO, GAP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_idx;
   logic [1:0]    stage;
   logic [7:0]    code;
   logic          pressed;

   logic [1:0]    clk_sync;
   logic          line_high;

   logic          ev_take;
   logic [7:0]    ev_code;
   logic          ev_ext;
   logic          ev_pressed;

   logic [7:0]    cur_byte;
   logic [10:0]   frame;
   logic [3:0]    next_idx;
   logic [1:0]    first_stage;
   logic [1:0]    next_stage;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         clk_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk_i};
      end
   end

   assign line_high = clk_sync[1];

`ifdef PS2_TX_FIFO_EN
   logic [9:0] fifo_mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] fill;
   logic [2:0] fill_next;
   logic       ready;
   logic       push;
   logic       pop;

   // ready already reflects a full FIFO, so a same-cycle pop cannot admit a push.
   assign push = key_valid_i & ready;
   assign pop  = (state == IDLE) & (fill != 3'd0);

   always_comb begin
      fill_next = fill;
      if (push && !pop) begin
         fill_next = fill + 3'd1;
      end else if (pop && !push) begin
         fill_next = fill - 3'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {key_code_i, key_ext_i, key_pressed_i};
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
         ready  <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         fill  <= fill_next;
         ready <= (fill_next != 3'd4);
      end
   end

   assign ev_take                        = pop;
   assign {ev_code, ev_ext, ev_pressed}  = fifo_mem[rd_ptr];
   assign key_ready_o                    = ready;
`else
   assign ev_take     = key_valid_i & key_ready_o;
   assign ev_code     = key_code_i;
   assign ev_ext      = key_ext_i;
   assign ev_pressed  = key_pressed_i;
   assign key_ready_o = (state == IDLE);
`endif

   always_comb begin
      cur_byte = code;
      if (stage == STG_E0) begin
         cur_byte = 8'hE0;
      end else if (stage == STG_F0) begin
         cur_byte = 8'hF0;
      end
   end

   // stop, odd parity, D7..D0, start -- index 0 goes out first
   assign frame       = {1'b1, ~^cur_byte, cur_byte, 1'b0};
   assign next_idx    = bit_idx + 4'd1;
   assign first_stage = ev_ext ? STG_E0 : (ev_pressed ? STG_CODE : STG_F0);
   assign next_stage  = (stage == STG_E0 && !pressed) ? STG_F0 : STG_CODE;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         stage      <= STG_CODE;
         code       <= '0;
         pressed    <= 1'b0;
         ps2_clk_o  <= 1'b1;
         ps2_data_o <= 1'b1;
         busy_o     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ev_take) begin
                  code    <= ev_code;
                  pressed <= ev_pressed;
                  stage   <= first_stage;
                  bit_idx <= '0;
                  cnt     <= '0;
                  busy_o  <= 1'b1;
                  state   <= LINECHK;
               end
            end
            LINECHK: begin
               if (line_high) begin
                  state      <= BIT_HI;
                  cnt        <= '0;
                  bit_idx    <= '0;
                  ps2_clk_o  <= 1'b1;
                  ps2_data_o <= 1'b0;
               end
            end
            BIT_HI: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  // Host pulled the clock low: back off and resend this byte from its start bit.
                  if (!line_high) begin
                     state      <= LINECHK;
                     bit_idx    <= '0;
                     ps2_clk_o  <= 1'b1;
                     ps2_data_o <= 1'b1;
                  end else begin
                     state     <= BIT_LO;
                     ps2_clk_o <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BIT_LO: begin
               if (cnt == HALF_LAST) begin
                  cnt       <= '0;
                  ps2_clk_o <= 1'b1;
                  if (bit_idx == 4'd10) begin
                     state      <= GAP;
                     ps2_data_o <= 1'b1;
                  end else begin
                     state      <= BIT_HI;
                     bit_idx    <= next_idx;
                     ps2_data_o <= frame[next_idx];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  if (stage == STG_CODE) begin
                     state  <= IDLE;
                     busy_o <= 1'b0;
                  end else begin
                     stage <= next_stage;
                     // The last gap cycle doubles as the line check so the gap is exactly GAP_CYC.
                     if (line_high) begin
                        state      <= BIT_HI;
                        ps2_clk_o  <= 1'b1;
                        ps2_data_o <= 1'b0;
                     end else begin
                        state <= LINECHK;
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               cnt        <= '0;
               ps2_clk_o  <= 1'b1;
               ps2_data_o <= 1'b1;
               busy_o     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_scancode_tx.sv
// Self-checking bench for ps2_scancode_tx: a line monitor decodes frames and compares them
// against byte sequences built from the event rules.
module tb_ps2_scancode_tx;

   localparam int CLK_HALF = 4;
   localparam int GAP_CYC  = 8;

   logic       clk = 1'b0;
   logic       reset_n_i;
   logic       key_valid_i;
   logic       key_ready_o;
   logic [7:0] key_code_i;
   logic       key_ext_i;
   logic       key_pressed_i;
   logic       host_clk;
   logic       ps2_clk_i;
   logic       ps2_clk_o;
   logic       ps2_data_o;
   logic       busy_o;

   // Open-drain clock line: low if either side pulls it low.
   assign ps2_clk_i = host_clk & ps2_clk_o;

   ps2_scancode_tx #(.CLK_HALF(CLK_HALF), .GAP_CYC(GAP_CYC)) dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n_i),
      .key_valid_i  (key_valid_i),
      .key_ready_o  (key_ready_o),
      .key_code_i   (key_code_i),
      .key_ext_i    (key_ext_i),
      .key_pressed_i(key_pressed_i),
      .ps2_clk_i    (ps2_clk_i),
      .ps2_clk_o    (ps2_clk_o),
      .ps2_data_o   (ps2_data_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Line monitor state
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];
   int          gaps[$];
   logic [10:0] shreg;
   logic [10:0] last_frame;
   int          nbits = 0;
   int          falls = 0;
   int          aborts = 0;
   int          ferr = 0;
   int          hi_run = 0;
   int          rel_run = 0;
   int          frame_cyc = 0;
   int          frame_len = 0;
   int          tail_cnt = 0;
   int          last_tail = 0;
   bit          in_frame = 0;
   bit          tail_on = 0;
   logic        prev_clk = 1'b1;
   logic        prev_data = 1'b1;

   always begin
      @(posedge clk);
      #1;
      if (!reset_n_i) begin
         nbits     = 0;
         in_frame  = 0;
         tail_on   = 0;
         hi_run    = 0;
         rel_run   = 0;
         prev_clk  = 1'b1;
         prev_data = 1'b1;
      end else begin
         if (nbits == 0 && !in_frame && ps2_clk_o && !ps2_data_o && prev_data) begin
            gaps.push_back(rel_run);
            in_frame  = 1;
            frame_cyc = 0;
            tail_on   = 0;
         end else if (in_frame) begin
            frame_cyc++;
         end
         if (prev_clk && !ps2_clk_o) begin
            falls++;
            if (nbits < 11) shreg[nbits] = ps2_data_o;
            nbits++;
         end
         if (!prev_clk && ps2_clk_o && nbits == 11) begin
            last_frame = shreg;
            frame_len  = frame_cyc;
            if (shreg[0] !== 1'b0 || shreg[10] !== 1'b1 || (^shreg[9:1]) !== 1'b1) ferr++;
            rx_q.push_back(shreg[8:1]);
            nbits    = 0;
            in_frame = 0;
            tail_on  = 1;
            tail_cnt = 0;
         end
         hi_run = ps2_clk_o ? hi_run + 1 : 0;
         if (nbits > 0 && nbits < 11 && hi_run > CLK_HALF) begin
            aborts++;
            nbits    = 0;
            in_frame = 0;
         end
         rel_run = (ps2_clk_o && ps2_data_o) ? rel_run + 1 : 0;
         if (tail_on) begin
            if (busy_o) tail_cnt++;
            else begin
               last_tail = tail_cnt;
               tail_on   = 0;
            end
         end
         prev_clk  = ps2_clk_o;
         prev_data = ps2_data_o;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: byte sequence of one event.
   task automatic model_event(input logic [7:0] c, input logic e, input logic p);
      if (e) exp_q.push_back(8'hE0);
      if (!p) exp_q.push_back(8'hF0);
      exp_q.push_back(c);
   endtask

   function automatic logic [10:0] model_frame(input logic [7:0] b);
      logic [10:0] f;
      int ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = b[i];
         ones += int'(b[i]);
      end
      f[9]  = ((ones % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic compare_rx(input string tag);
      check($sformatf("%s_count", tag), rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic offer(input logic [7:0] c, input logic e, input logic p);
      int n = 0;
      key_code_i    = c;
      key_ext_i     = e;
      key_pressed_i = p;
      key_valid_i   = 1'b1;
      while (key_ready_o !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("offer_accept_in_time", n < 3000, 1);
      @(negedge clk);
      key_valid_i = 1'b0;
      model_event(c, e, p);
   endtask

   task automatic measure_start(output int lat);
      lat = 1;
      while (ps2_data_o !== 1'b0 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      int quiet = 0;
      while (quiet < 4 && n < 4000) begin
         @(negedge clk);
         n++;
         quiet = busy_o ? 0 : quiet + 1;
      end
      check($sformatf("%s_idle_in_time", tag), n < 4000, 1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      int cnt_bad;
      int idx;
      int first_full;
      bit will;
      logic [7:0] c;
      logic e, p;
      logic [7:0] bc[6];
      logic       be[6];
      logic       bp[6];

      reset_n_i = 1'b0; key_valid_i = 1'b0; key_code_i = '0;
      key_ext_i = 1'b0; key_pressed_i = 1'b0; host_clk = 1'b1;
      repeat (6) begin
         @(negedge clk);
         key_valid_i   = 1'($urandom);
         key_code_i    = 8'($urandom);
         key_ext_i     = 1'($urandom);
         key_pressed_i = 1'($urandom);
         host_clk      = 1'($urandom);
      end
      check("reset_clk_o", ps2_clk_o, 1);
      check("reset_data_o", ps2_data_o, 1);
      check("reset_ready", key_ready_o, 1);
      check("reset_busy", busy_o, 0);
      @(negedge clk);
      key_valid_i = 1'b0; host_clk = 1'b1; reset_n_i = 1'b1;
      repeat (4) @(negedge clk);
      $display("[TB] reset: clk_o=%0b data_o=%0b ready=%0b busy=%0b", ps2_clk_o, ps2_data_o, key_ready_o, busy_o);

      // Make 1C
      falls = 0; gaps.delete();
      offer(8'h1C, 1'b0, 1'b1);
      measure_start(lat);
      check("make1c_latency_le3", lat <= 3, 1);
      wait_idle("make1c");
      check("make1c_frame_bits", last_frame, 11'b10000111000);
      check("make1c_falls", falls, 11);
      check("make1c_frame_len", frame_len, 88);
      check("make1c_busy_tail", last_tail, GAP_CYC);
      check("make1c_framing", ferr, 0);
      $display("[TB] make 1C: frame=%b falls=%0d len=%0d tail=%0d lat=%0d", last_frame, falls, frame_len, last_tail, lat);
      compare_rx("make1c");

      // Break 75 extended
      falls = 0; gaps.delete();
      offer(8'h75, 1'b1, 1'b0);
      wait_idle("brk75");
      check("brk75_falls", falls, 33);
      check("brk75_frames", gaps.size(), 3);
      check("brk75_gap1", gaps[1], GAP_CYC);
      check("brk75_gap2", gaps[2], GAP_CYC);
      check("brk75_last_frame", last_frame, model_frame(8'h75));
      $display("[TB] break E0 75: falls=%0d bytes=%0d", falls, rx_q.size());
      compare_rx("brk75");

      // Random events
      for (int k = 0; k < 5; k++) begin
         c = 8'($urandom); e = 1'($urandom); p = 1'($urandom);
         falls = 0;
         offer(c, e, p);
         measure_start(lat);
         check($sformatf("rand%0d_latency_le3", k), lat <= 3, 1);
         wait_idle($sformatf("rand%0d", k));
         check($sformatf("rand%0d_falls", k), falls, 11 * exp_q.size());
         check($sformatf("rand%0d_last_frame", k), last_frame, model_frame(c));
         check($sformatf("rand%0d_framing", k), ferr, 0);
         $display("[TB] random event code=%02h ext=%0b pressed=%0b bytes=%0d", c, e, p, rx_q.size());
         compare_rx($sformatf("rand%0d", k));
      end

      // Host inhibit before acceptance
      host_clk = 1'b0;
      repeat (3) @(negedge clk);
      falls = 0;
      offer(8'h5A, 1'b0, 1'b1);
      cnt_bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (ps2_clk_o !== 1'b1) cnt_bad++;
      end
      check("inhibit_clk_low_cycles", cnt_bad, 0);
      check("inhibit_falls", falls, 0);
      check("inhibit_busy", busy_o, 1);
      host_clk = 1'b1;
      @(negedge clk);
      measure_start(lat);
      check("inhibit_release_latency_le3", lat <= 3, 1);
      wait_idle("inhibit");
      $display("[TB] inhibit: release latency=%0d", lat);
      compare_rx("inhibit");

      // Host abort during D3 of F0
      falls = 0; aborts = 0;
      offer(8'h75, 1'b1, 1'b0);
      n = 0;
      while (rx_q.size() < 1 && n < 2000) begin @(negedge clk); n++; end
      check("abort_wait_e0", n < 2000, 1);
      n = 0;
      while (!(nbits == 4 && ps2_clk_o === 1'b1) && n < 2000) begin @(negedge clk); n++; end
      check("abort_wait_d3", n < 2000, 1);
      host_clk = 1'b0;
      repeat (10) @(negedge clk);
      cnt_bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (ps2_clk_o !== 1'b1 || ps2_data_o !== 1'b1) cnt_bad++;
      end
      check("abort_lines_released", cnt_bad, 0);
      check("abort_falls_partial", falls, 15);
      check("abort_detected", aborts, 1);
      check("abort_busy", busy_o, 1);
      host_clk = 1'b1;
      wait_idle("abort");
      check("abort_falls_total", falls, 37);
      $display("[TB] abort: falls=%0d aborts=%0d bytes=%0d", falls, aborts, rx_q.size());
      compare_rx("abort");

      // Back-to-back events
      for (int k = 0; k < 6; k++) begin
         bc[k] = 8'($urandom); be[k] = 1'($urandom); bp[k] = 1'($urandom);
      end
      idx = 0; n = 0; cnt_bad = 0; first_full = -1;
      key_code_i = bc[0]; key_ext_i = be[0]; key_pressed_i = bp[0]; key_valid_i = 1'b1;
      while (idx < 6 && n < 6000) begin
         will = (key_ready_o === 1'b1);
         @(negedge clk);
         n++;
         if (will) begin
            model_event(bc[idx], be[idx], bp[idx]);
            idx++;
`ifndef PS2_TX_FIFO_EN
            check($sformatf("b2b_ready_low_after_accept%0d", idx), key_ready_o, 0);
`endif
            if (idx < 6) begin
               key_code_i = bc[idx]; key_ext_i = be[idx]; key_pressed_i = bp[idx];
            end
         end
`ifdef PS2_TX_FIFO_EN
         if (key_ready_o !== 1'b1 && first_full < 0) first_full = idx;
`else
         if (key_ready_o !== !busy_o) cnt_bad++;
`endif
      end
      key_valid_i = 1'b0;
      check("b2b_all_accepted", idx, 6);
`ifdef PS2_TX_FIFO_EN
      check("b2b_accepts_before_full", first_full, 5);
`else
      check("b2b_ready_tracks_idle", cnt_bad, 0);
`endif
      wait_idle("b2b");
      $display("[TB] back-to-back: accepted=%0d bytes=%0d", idx, rx_q.size());
      compare_rx("b2b");

      // Reset mid-frame
      offer(8'h1C, 1'b0, 1'b1);
      n = 0;
      while (nbits < 5 && n < 2000) begin @(negedge clk); n++; end
      check("midrst_wait", n < 2000, 1);
      #2;
      reset_n_i = 1'b0;
      #1;
      check("midrst_clk_o", ps2_clk_o, 1);
      check("midrst_data_o", ps2_data_o, 1);
      check("midrst_ready", key_ready_o, 1);
      check("midrst_busy", busy_o, 0);
      @(negedge clk);
      reset_n_i = 1'b1;
      exp_q.delete();
      falls = 0;
      repeat (300) @(negedge clk);
      check("midrst_no_falls", falls, 0);
      check("midrst_busy_after", busy_o, 0);
      $display("[TB] mid-frame reset: falls after=%0d", falls);
      compare_rx("midrst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
